// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_writer
// Description : Buffers filtered pixels from the convolution stage in a small
//               FIFO and writes them to the output SRAM in serpentine scan
//               order (even rows left->right, odd rows right->left).
//               Signals frame completion with a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_writer #(
  parameter int X_MAX       = 60,
  parameter int Y_MAX       = 60,
  parameter int PIXEL_DEPTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     new_trans,
  input  logic [$clog2(X_MAX):0]   max_x,
  input  logic [$clog2(Y_MAX):0]   max_y,
  input  logic                     result_valid,
  input  logic [PIXEL_DEPTH-1:0]   result_pixel,
  output logic                     result_ready,
  input  logic                     sram_busy,
  output logic [$clog2(X_MAX):0]   x_addr_out,
  output logic [$clog2(Y_MAX):0]   y_addr_out,
  output logic                     wen_out,
  output logic [PIXEL_DEPTH-1:0]   wdat_out,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int c_xw = $clog2(X_MAX) + 1;
  localparam int c_yw = $clog2(Y_MAX) + 1;
  localparam int c_cw = $clog2(X_MAX * Y_MAX) + 1;
  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam logic [c_pw:0]     c_fifo_full = (c_pw + 1)'(FIFO_DEPTH);
  localparam logic [c_xw-1:0]   c_x_one     = c_xw'(1);
  localparam logic [c_yw-1:0]   c_y_one     = c_yw'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_xw-1:0]         r_max_x;
  logic [c_yw-1:0]         r_max_y;
  logic [c_xw-1:0]         r_x;
  logic [c_yw-1:0]         r_y;
  logic                    r_dir_left;
  logic [c_cw-1:0]         r_total;
  logic [c_cw-1:0]         r_accepted;
  logic [PIXEL_DEPTH-1:0]  r_mem [FIFO_DEPTH];
  logic [c_pw-1:0]         r_wr_ptr;
  logic [c_pw-1:0]         r_rd_ptr;
  logic [c_pw:0]           r_count;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_at_end;
  logic w_dims_ok;

  // Ready depends only on registered state, so valid/busy never loop back into it
  assign w_ready      = (r_state == S_RUN) && (r_count < c_fifo_full) && (r_accepted < r_total);
  assign result_ready = w_ready;
  assign w_push       = result_valid && w_ready;
  assign w_pop        = (r_state == S_RUN) && (r_count != '0) && !sram_busy;
  assign w_dims_ok    = (max_x != '0) && (max_y != '0);
  assign busy         = (r_state != S_IDLE);

  // Last pixel of the frame: bottom row, at the column where that row's walk ends
  assign w_at_end = (r_y == r_max_y - c_y_one) &&
                    (r_x == (r_max_y[0] ? r_max_x - c_x_one : '0));

  // FIFO storage; data needs no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (w_push && !new_trans) begin
      r_mem[r_wr_ptr] <= result_pixel;
    end
  end

  // Control FSM, FIFO pointers, scan position and registered write port
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_max_x    <= '0;
      r_max_y    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_dir_left <= 1'b0;
      r_total    <= '0;
      r_accepted <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      wen_out    <= 1'b0;
      wdat_out   <= '0;
      x_addr_out <= '0;
      y_addr_out <= '0;
      frame_done <= 1'b0;
    end else begin
      wen_out    <= 1'b0;
      frame_done <= 1'b0;
      if (new_trans) begin
        // A new frame discards anything in flight, including this cycle's push/pop
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_x        <= '0;
        r_y        <= '0;
        r_dir_left <= 1'b0;
        r_accepted <= '0;
        r_max_x    <= max_x;
        r_max_y    <= max_y;
        r_total    <= c_cw'(max_x) * c_cw'(max_y);
        // An empty frame would never complete, so it parks the writer in IDLE
        r_state    <= w_dims_ok ? S_RUN : S_IDLE;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_push) begin
              r_wr_ptr   <= r_wr_ptr + 1'b1;
              r_accepted <= r_accepted + 1'b1;
            end
            if (w_pop) begin
              r_rd_ptr   <= r_rd_ptr + 1'b1;
              wen_out    <= 1'b1;
              wdat_out   <= r_mem[r_rd_ptr];
              x_addr_out <= r_x;
              y_addr_out <= r_y;
              if (r_dir_left) begin
                if (r_x == '0) begin
                  r_y        <= r_y + c_y_one;
                  r_dir_left <= 1'b0;
                end else begin
                  r_x <= r_x - c_x_one;
                end
              end else begin
                if (r_x == r_max_x - c_x_one) begin
                  r_y        <= r_y + c_y_one;
                  r_dir_left <= 1'b1;
                end else begin
                  r_x <= r_x + c_x_one;
                end
              end
              if (w_at_end) begin
                r_state <= S_DONE;
              end
            end
            if (w_push && !w_pop) begin
              r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
              r_count <= r_count - 1'b1;
            end
          end
          S_DONE: begin
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Self-checking bench for conv_result_writer. Randomised pixel
//               streams are compared against a serpentine address model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_writer;

  localparam int XW = $clog2(60) + 1;
  localparam int YW = $clog2(60) + 1;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          new_trans = 1'b0;
  logic [XW-1:0] max_x = '0;
  logic [YW-1:0] max_y = '0;
  logic          result_valid = 1'b0;
  logic [7:0]    result_pixel = '0;
  logic          sram_busy = 1'b0;
  logic          result_ready;
  logic [XW-1:0] x_addr_out;
  logic [YW-1:0] y_addr_out;
  logic          wen_out;
  logic [7:0]    wdat_out;
  logic          frame_done;
  logic          busy;

  conv_result_writer #(
    .X_MAX(60), .Y_MAX(60), .PIXEL_DEPTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans),
    .max_x(max_x), .max_y(max_y),
    .result_valid(result_valid), .result_pixel(result_pixel),
    .result_ready(result_ready), .sram_busy(sram_busy),
    .x_addr_out(x_addr_out), .y_addr_out(y_addr_out),
    .wen_out(wen_out), .wdat_out(wdat_out),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write recorder: logs every SRAM write and frame_done pulse with its cycle number
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int wx[$];
  int wy[$];
  int wd[$];
  int wc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wen_out) begin
      wx.push_back(int'(x_addr_out));
      wy.push_back(int'(y_addr_out));
      wd.push_back(int'(wdat_out));
      wc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Serpentine reference: i-th pixel of a frame of width w
  function automatic int exp_x(input int w, input int i);
    int row = i / w;
    int k   = i % w;
    return (row % 2 == 0) ? k : (w - 1 - k);
  endfunction

  task automatic clear_rec();
    wx.delete(); wy.delete(); wd.delete(); wc.delete();
  endtask

  task automatic rand_pix(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(1, 255)));
  endtask

  // Called at posedge+1; returns at posedge+1 with new_trans low
  task automatic start_frame(input int w, input int h);
    max_x = XW'(w);
    max_y = YW'(h);
    result_valid = 1'b0;
    new_trans = 1'b1;
    @(posedge clk); #1;
    new_trans = 1'b0;
  endtask

  // Offers pixels in order; stops after stop_after accepts (if >0), on frame_done, or on timeout
  task automatic drive(input logic [7:0] pix[$], input int stop_after, input bit rnd,
                       output int nacc, output bit tmo);
    int idx = 0;
    int cycles = 0;
    int d0 = done_cnt;
    forever begin
      result_valid = (idx < pix.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (idx < pix.size()) result_pixel = pix[idx];
      sram_busy = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (result_valid && result_ready) idx++;
      cycles++;
      if ((stop_after > 0 && idx >= stop_after) || done_cnt != d0 || cycles > TMO) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    result_valid = 1'b0;
    sram_busy = 1'b0;
    nacc = idx;
    tmo = (cycles > TMO);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b need 0", result_ready); end
    checks++; if (wen_out !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b need 0", wen_out); end
    checks++; if (wdat_out !== 8'd0) begin errors++; $display("FAIL reset_wdat: got %0d need 0", wdat_out); end
    checks++; if (x_addr_out !== '0 || y_addr_out !== '0) begin errors++; $display("FAIL reset_addr: got (%0d,%0d) need (0,0)", x_addr_out, y_addr_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || result_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b ready=%b need 0/0", busy, result_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_dim();
    int d0 = done_cnt;
    start_frame(0, 3);
    #1;
    checks++; if (busy !== 1'b0 || result_ready !== 1'b0) begin errors++; $display("FAIL zero_dim_idle: busy=%b ready=%b need 0/0", busy, result_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL zero_dim_done: got %0d pulses need 0", done_cnt - d0); end
  endtask

  task automatic test_3x2();
    logic [7:0] pix[$];
    int nacc, s, d0, n;
    bit tmo;
    pix = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    n = 6;
    clear_rec();
    d0 = done_cnt;
    start_frame(3, 2);
    s = cyc;
    #1;
    checks++; if (result_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL 3x2_ready_after_start: ready=%b busy=%b need 1/1", result_ready, busy); end
    drive(pix, 0, 1'b0, nacc, tmo);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL 3x2_timeout: frame_done not seen within %0d cycles", TMO); end
    checks++; if (wx.size() != n) begin errors++; $display("FAIL 3x2_write_count: got %0d need %0d", wx.size(), n); end
    for (int i = 0; i < n && i < wx.size(); i++) begin
      checks++;
      if (wx[i] != exp_x(3, i) || wy[i] != i / 3 || wd[i] != int'(pix[i])) begin
        errors++;
        $display("FAIL 3x2_write[%0d]: got (%0d,%0d)=%0d need (%0d,%0d)=%0d", i, wx[i], wy[i], wd[i], exp_x(3, i), i / 3, pix[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL 3x2_done_count: got %0d need 1", done_cnt - d0); end
    if (wc.size() == n) begin
      checks++; if (wc[0] != s + 2) begin errors++; $display("FAIL 3x2_latency: first write cycle %0d need %0d", wc[0], s + 2); end
      checks++; if (wc[n-1] - wc[0] != n - 1) begin errors++; $display("FAIL 3x2_throughput: span %0d need %0d", wc[n-1] - wc[0], n - 1); end
      checks++; if (done_cyc != wc[n-1] + 1) begin errors++; $display("FAIL 3x2_done_timing: done cycle %0d need %0d", done_cyc, wc[n-1] + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pix[$];
    logic [7:0] rest[$];
    int acc = 0, wen_seen = 0, nacc, d0;
    logic rdy_last = 1'b1;
    bit tmo;
    rand_pix(16, pix);
    clear_rec();
    d0 = done_cnt;
    start_frame(4, 4);
    for (int c = 0; c < 8; c++) begin
      result_valid = 1'b1;
      result_pixel = pix[acc];
      sram_busy = 1'b1;
      @(negedge clk);
      if (wen_out) wen_seen++;
      if (c == 7) rdy_last = result_ready;
      if (result_valid && result_ready) acc++;
      @(posedge clk); #1;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts_while_busy: got %0d need 4", acc); end
    checks++; if (rdy_last !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b need 0", rdy_last); end
    checks++; if (wen_seen != 0) begin errors++; $display("FAIL bp_write_while_busy: got %0d writes need 0", wen_seen); end
    for (int i = 4; i < 16; i++) rest.push_back(pix[i]);
    drive(rest, 0, 1'b0, nacc, tmo);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout: frame_done not seen within %0d cycles", TMO); end
    checks++; if (wx.size() != 16) begin errors++; $display("FAIL bp_write_count: got %0d need 16", wx.size()); end
    for (int i = 0; i < 16 && i < wx.size(); i++) begin
      checks++;
      if (wx[i] != exp_x(4, i) || wy[i] != i / 4 || wd[i] != int'(pix[i])) begin
        errors++;
        $display("FAIL bp_write[%0d]: got (%0d,%0d)=%0d need (%0d,%0d)=%0d", i, wx[i], wy[i], wd[i], exp_x(4, i), i / 4, pix[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_single_col();
    logic [7:0] pix[$];
    int nacc, d0;
    bit tmo;
    pix = '{8'd7, 8'd8, 8'd9};
    clear_rec();
    d0 = done_cnt;
    start_frame(1, 3);
    drive(pix, 0, 1'b1, nacc, tmo);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL col_timeout: frame_done not seen within %0d cycles", TMO); end
    checks++; if (wx.size() != 3) begin errors++; $display("FAIL col_write_count: got %0d need 3", wx.size()); end
    for (int i = 0; i < 3 && i < wx.size(); i++) begin
      checks++;
      if (wx[i] != 0 || wy[i] != i || wd[i] != int'(pix[i])) begin
        errors++;
        $display("FAIL col_write[%0d]: got (%0d,%0d)=%0d need (0,%0d)=%0d", i, wx[i], wy[i], wd[i], i, pix[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL col_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    logic [7:0] pix_a[$];
    logic [7:0] pix_b[$];
    int nacc, d0, base;
    bit tmo;
    rand_pix(16, pix_a);
    rand_pix(16, pix_b);
    clear_rec();
    d0 = done_cnt;
    start_frame(4, 4);
    drive(pix_a, 5, 1'b1, nacc, tmo);
    checks++; if (nacc != 5) begin errors++; $display("FAIL abort_pre_accepts: got %0d need 5", nacc); end
    start_frame(4, 4);
    base = wx.size();
    drive(pix_b, 0, 1'b1, nacc, tmo);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL abort_timeout: frame_done not seen within %0d cycles", TMO); end
    checks++; if (wx.size() - base != 16) begin errors++; $display("FAIL abort_write_count: got %0d need 16", wx.size() - base); end
    for (int i = 0; i < 16 && base + i < wx.size(); i++) begin
      checks++;
      if (wx[base+i] != exp_x(4, i) || wy[base+i] != i / 4 || wd[base+i] != int'(pix_b[i])) begin
        errors++;
        $display("FAIL abort_write[%0d]: got (%0d,%0d)=%0d need (%0d,%0d)=%0d", i, wx[base+i], wy[base+i], wd[base+i], exp_x(4, i), i / 4, pix_b[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_oversupply();
    logic [7:0] pix[$];
    int nacc, d0, extra = 0;
    bit tmo;
    rand_pix(10, pix);
    clear_rec();
    d0 = done_cnt;
    start_frame(3, 3);
    drive(pix, 9, 1'b0, nacc, tmo);
    result_valid = 1'b1;
    result_pixel = pix[9];
    @(negedge clk);
    checks++; if (result_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL over_ready_after_9: ready=%b busy=%b need 0/1", result_ready, busy); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (result_valid && result_ready) extra++;
    end
    @(posedge clk); #1;
    result_valid = 1'b0;
    checks++; if (nacc != 9 || extra != 0) begin errors++; $display("FAIL over_accepts: got %0d need 9", nacc + extra); end
    checks++; if (wx.size() != 9) begin errors++; $display("FAIL over_write_count: got %0d need 9", wx.size()); end
    for (int i = 0; i < 9 && i < wx.size(); i++) begin
      checks++;
      if (wx[i] != exp_x(3, i) || wy[i] != i / 3 || wd[i] != int'(pix[i])) begin
        errors++;
        $display("FAIL over_write[%0d]: got (%0d,%0d)=%0d need (%0d,%0d)=%0d", i, wx[i], wy[i], wd[i], exp_x(3, i), i / 3, pix[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL over_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pix[$];
    logic [7:0] pix2[$];
    int nacc, d0;
    bit tmo;
    rand_pix(16, pix);
    rand_pix(4, pix2);
    start_frame(4, 4);
    drive(pix, 6, 1'b1, nacc, tmo);
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (result_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: ready=%b busy=%b done=%b need 0/0/0", result_ready, busy, frame_done); end
    checks++; if (wen_out !== 1'b0 || wdat_out !== 8'd0) begin errors++; $display("FAIL rst_mid_data: wen=%b wdat=%0d need 0/0", wen_out, wdat_out); end
    checks++; if (x_addr_out !== '0 || y_addr_out !== '0) begin errors++; $display("FAIL rst_mid_addr: got (%0d,%0d) need (0,0)", x_addr_out, y_addr_out); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    clear_rec();
    d0 = done_cnt;
    start_frame(2, 2);
    drive(pix2, 0, 1'b1, nacc, tmo);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL rst_timeout: frame_done not seen within %0d cycles", TMO); end
    checks++; if (wx.size() != 4) begin errors++; $display("FAIL rst_write_count: got %0d need 4", wx.size()); end
    for (int i = 0; i < 4 && i < wx.size(); i++) begin
      checks++;
      if (wx[i] != exp_x(2, i) || wy[i] != i / 2 || wd[i] != int'(pix2[i])) begin
        errors++;
        $display("FAIL rst_write[%0d]: got (%0d,%0d)=%0d need (%0d,%0d)=%0d", i, wx[i], wy[i], wd[i], exp_x(2, i), i / 2, pix2[i]);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rst_done_count: got %0d need 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_zero_dim();
    test_3x2();
    test_backpressure();
    test_single_col();
    test_abort();
    test_oversupply();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_result_writer.md
# conv_result_writer

Write-side counterpart of the convolution window reader. It accepts filtered pixels from the Gaussian convolution stage over a valid/ready handshake and buffers them in a small FIFO. It writes them into the output image SRAM at addresses generated in the same serpentine scan order the window reader walks: row 0 left to right, row 1 right to left, and so on. It reports frame completion to the top-level controller.

## Interface
- X_MAX, 60, max output image width in pixels
- Y_MAX, 60, max output image height in pixels
- PIXEL_DEPTH, 8, bits per pixel
- FIFO_DEPTH, 4, result buffer entries (power of 2, ≥2)

- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- new_trans  in  1  start new frame; latches max_x/max_y, flushes FIFO
- max_x  in  $clog2(X_MAX)+1  output frame width (1..X_MAX)
- max_y  in  $clog2(Y_MAX)+1  output frame height (1..Y_MAX)
- result_valid  in  1  conv stage presents a pixel
- result_pixel  in  PIXEL_DEPTH  filtered pixel
- result_ready  out  1  writer accepts pixel this cycle
- sram_busy  in  1  output SRAM write port unavailable this cycle
- x_addr_out  out  $clog2(X_MAX)+1  write column
- y_addr_out  out  $clog2(Y_MAX)+1  write row
- wen_out  out  1  write strobe, one cycle per pixel
- wdat_out  out  PIXEL_DEPTH  write data
- frame_done  out  1  one-cycle pulse after last pixel written
- busy  out  1  high in RUN and DONE

## Operation
- States:
  - IDLE:
    - new_trans with max_x≠0 and max_y≠0 → RUN.
    - new_trans with either dimension 0 → stay IDLE, no frame_done.
  - RUN: accept and write pixels. The write of the pixel at the end position → DONE.
  - DONE: frame_done=1 for one cycle → IDLE.
- new_trans in RUN or DONE:
  - flush FIFO (count=0)
  - position=(0,0), dir=RIGHT, accept counter=0
  - relatch dimensions, state=RUN
  - frame_done not pulsed for the aborted frame.
- Accept:
  - result_ready = (state==RUN) && (fifo_count<FIFO_DEPTH) && (accepted < max_x*max_y).
  - It is computed from registered state only; no combinational path from result_valid or sram_busy.
  - A push happens when result_valid && result_ready.
  - Pixels beyond max_x*max_y are never accepted.
- Write:
  - Each cycle in RUN with fifo_count>0 and !sram_busy, pop the head.
  - On the next edge register wen_out=1, wdat_out=head, x/y_addr_out=current position, then advance position.
  - Otherwise wen_out=0; addr/data hold their last values.
- Push and pop in the same cycle: count unchanged; a push into a full FIFO is impossible because ready=0.
- Position advance (serpentine):
  - dir=RIGHT: x+1 until x==max_x-1, then y+1, dir=LEFT.
  - dir=LEFT: x-1 until x==0, then y+1, dir=RIGHT.
  - max_x==1: every advance is y+1, with dir toggling.
- End position: y==max_y-1 and x==(max_y odd ? max_x-1 : 0). Writing it → DONE.
- Arithmetic:
  - Accept counter width is $clog2(X_MAX*Y_MAX)+1.
  - max_x*max_y is computed once at latch time into a register.

## Timing
- Reset values: result_ready=0, wen_out=0, wdat_out=0, x_addr_out=0, y_addr_out=0, frame_done=0, busy=0; state IDLE; FIFO empty.
- new_trans at edge N: state=RUN at N+1, result_ready can be 1 in cycle N+1.
- Latency: a pixel accepted at edge N into an empty FIFO with sram_busy=0 gives wen_out=1 in cycle N+1 (the cycle after edge N+1).
- Throughput: 1 pixel/cycle sustained with sram_busy=0.
- frame_done is high in the cycle immediately after the final wen_out cycle.
- sram_busy=1 stalls pops only; accepts continue until FIFO_DEPTH entries.
- n_rst asserted mid-frame: all state and outputs clear asynchronously; FIFO contents are discarded.

## Test plan
- 3x2 frame, continuous valid, pixels 10..15 → writes (0,0)=10, (1,0)=11, (2,0)=12, (2,1)=13, (1,1)=14, (0,1)=15; frame_done pulses once, one cycle after the last write.
- Backpressure: sram_busy=1 for 8 cycles during a 4x4 frame → result_ready drops after 4 accepts; no pixel lost or duplicated; order is preserved after release.
- max_x=1, max_y=3, pixels 7,8,9 → writes (0,0)=7, (0,1)=8, (0,2)=9; frame_done pulses.
- new_trans asserted after 5 of 16 pixels (4x4) → FIFO flushed; the next write lands at (0,0); no frame_done for the aborted frame; the new frame completes normally.
- Over-supply: result_valid held high for 10 pixels on a 3x3 frame → only 9 accepted; result_ready=0 after the 9th; 9 writes occur.
- n_rst pulsed mid-frame → all outputs 0 immediately; a subsequent new_trans with 2x2 writes (0,0), (1,0), (1,1), (0,1).
